// File: rtl/alu_share_arb_pkg.sv
// Shared ALU opcodes and arbiter encodings for alu_share_arb.
// Optional feature macro: ALU_ARB_PERF_EN (grant counters in the top).
package alu_share_arb_pkg;

  localparam int ARB_NREQ = 2;
  localparam int ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] OP_ADD  = 5'd0;
  localparam logic [ALU_OP_W-1:0] OP_SUB  = 5'd1;
  localparam logic [ALU_OP_W-1:0] OP_AND  = 5'd2;
  localparam logic [ALU_OP_W-1:0] OP_OR   = 5'd3;
  localparam logic [ALU_OP_W-1:0] OP_XOR  = 5'd4;
  localparam logic [ALU_OP_W-1:0] OP_SLL  = 5'd5;
  localparam logic [ALU_OP_W-1:0] OP_SRL  = 5'd6;
  localparam logic [ALU_OP_W-1:0] OP_SRA  = 5'd7;
  localparam logic [ALU_OP_W-1:0] OP_SLT  = 5'd8;
  localparam logic [ALU_OP_W-1:0] OP_SLTU = 5'd9;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_e;

  function automatic logic gnt_idx(input logic [ARB_NREQ-1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/alu_share_arb_rr.sv
// Two-way round-robin arbiter; on a tie the port that did not win last time wins.
// Used by alu_share_arb (ALU_ARB_PERF_EN does not affect this block).
module rr_arb2
  import alu_share_arb_pkg::*;
(
  input  logic [ARB_NREQ-1:0] req,
  input  logic                last_gnt,
  input  logic                en,
  output logic [ARB_NREQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (en) begin
      unique case (1'b1)
        (req == 2'b11): gnt = last_gnt ? 2'b01 : 2'b10;
        (req == 2'b01): gnt = 2'b01;
        (req == 2'b10): gnt = 2'b10;
        default:        gnt = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters with a registered response.
// `define ALU_ARB_PERF_EN adds per-port accepted-op counters grant_cnt0/grant_cnt1.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ARB_NREQ-1:0]        req_valid,
  output logic [ARB_NREQ-1:0]        req_ready,
  input  logic [ARB_NREQ*DATA_W-1:0] req_src0,
  input  logic [ARB_NREQ*DATA_W-1:0] req_src1,
  input  logic [ARB_NREQ*OP_W-1:0]   req_op,
  output logic [ARB_NREQ-1:0]        resp_valid,
  input  logic [ARB_NREQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]          resp_data,
  output logic [DATA_W-1:0]          alu_src0,
  output logic [DATA_W-1:0]          alu_src1,
  output logic [OP_W-1:0]            alu_op,
  input  logic [DATA_W-1:0]          alu_res
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]                grant_cnt0,
  output logic [31:0]                grant_cnt1
`endif
);

  arb_state_e          state_q;
  arb_state_e          state_d;
  logic                owner_q;
  logic                last_q;
  logic [DATA_W-1:0]   data_q;
  logic [ARB_NREQ-1:0] gnt;
  logic                can_accept;
  logic                hs;
  logic                gsel;

  // A held result frees the slot in the same cycle its owner accepts it.
  assign can_accept = (state_q == ARB_IDLE) |
                      ((state_q == ARB_RESP) & resp_ready[owner_q]);

  rr_arb2 u_arb (
    .req      (req_valid),
    .last_gnt (last_q),
    .en       (can_accept),
    .gnt      (gnt)
  );

  assign req_ready = gnt;
  assign hs        = |gnt;
  assign gsel      = gnt_idx(gnt);

  always_comb begin
    alu_src0 = '0;
    alu_src1 = '0;
    alu_op   = OP_W'(OP_ADD);
    unique case (1'b1)
      gnt[0]: begin
        alu_src0 = req_src0[0 +: DATA_W];
        alu_src1 = req_src1[0 +: DATA_W];
        alu_op   = req_op[0 +: OP_W];
      end
      gnt[1]: begin
        alu_src0 = req_src0[DATA_W +: DATA_W];
        alu_src1 = req_src1[DATA_W +: DATA_W];
        alu_op   = req_op[OP_W +: OP_W];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (hs) state_d = ARB_RESP;
      ARB_RESP: begin
        if (hs)
          state_d = ARB_RESP;
        else if (resp_ready[owner_q])
          state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        data_q  <= alu_res;
        owner_q <= gsel;
        last_q  <= gsel;
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == ARB_RESP)
      resp_valid[owner_q] = 1'b1;
  end

  assign resp_data = data_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] cnt0_q;
  logic [31:0] cnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt[0]) cnt0_q <= cnt0_q + 32'd1;
      if (gnt[1]) cnt1_q <= cnt1_q + 32'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule
